// File: rtl/vending_change_controller.sv
// Vending credit/stock controller: accepts coins, dispenses items and pays change back
// greedily, one coin per cycle, on an idle timeout or on request.
module vending_change_controller #(
   parameter int NUM_COINS   = 3,
   parameter int NUM_ITEMS   = 4,
   parameter int TOTAL_BITS  = 31,
   parameter int STOCK_BITS  = 4,
   parameter int STOCK_INIT  = 5,
   parameter int WAIT_CYCLES = 100,
   parameter logic [NUM_COINS*32-1:0] COIN_VALUES = {32'd1000, 32'd500, 32'd100},
   parameter logic [NUM_ITEMS*32-1:0] ITEM_PRICES = {32'd2000, 32'd1000, 32'd500, 32'd400}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_COINS-1:0]  i_input_coin,
   input  logic [NUM_ITEMS-1:0]  i_select_item,
   input  logic                  i_trigger_return,
   input  logic                  i_restock,
   input  logic [NUM_ITEMS-1:0]  i_restock_item,
   input  logic [STOCK_BITS-1:0] i_restock_qty,
   output logic [NUM_ITEMS-1:0]  o_available_item,
   output logic [NUM_ITEMS-1:0]  o_output_item,
   output logic [NUM_COINS-1:0]  o_return_coin,
   output logic [TOTAL_BITS-1:0] o_current_total,
   output logic                  o_busy
);

   localparam int CW = ((TOTAL_BITS > 32) ? TOTAL_BITS : 32) + 1;
   localparam int TW = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0]         CREDIT_MAX = CW'({TOTAL_BITS{1'b1}});
   localparam logic [STOCK_BITS:0]   STOCK_MAX  = {1'b0, {STOCK_BITS{1'b1}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CREDIT = 2'd1, S_RETURN = 2'd2} state_t;
   typedef logic [NUM_ITEMS-1:0][STOCK_BITS-1:0] stock_t;

   state_t                state_q, state_d;
   logic [TOTAL_BITS-1:0] credit_q, credit_d;
   logic [TW-1:0]         timer_q, timer_d;
   stock_t                stock_q, stock_d;
   logic [NUM_ITEMS-1:0]  item_q, item_d, avail_q, avail_d;
   logic [NUM_COINS-1:0]  coin_q, coin_d;
   logic                  busy_q, busy_d;

   logic [CW-1:0]         credit_ext_s, coin_val_s, price_s, ret_val_s;
   logic [NUM_COINS-1:0]  coin_oh_s, fit_s, ret_oh_s;
   logic [NUM_ITEMS-1:0]  item_oh_s, restock_oh_s;
   logic                  coin_ok_s, sel_ok_s;
   logic [STOCK_BITS:0]   stock_sum_s;

   function automatic logic [CW-1:0] coin_value(input int idx);
      return CW'(COIN_VALUES[idx*32 +: 32]);
   endfunction

   function automatic logic [CW-1:0] item_price(input int idx);
      return CW'(ITEM_PRICES[idx*32 +: 32]);
   endfunction

   function automatic logic [NUM_ITEMS-1:0] avail_of(input state_t st,
                                                     input logic [TOTAL_BITS-1:0] cr,
                                                     input stock_t stk);
      logic [NUM_ITEMS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         v[i] = (item_price(i) <= CW'(cr)) && (stk[i] != '0) && (st != S_RETURN);
      end
      return v;
   endfunction

   // Lowest-index decode of request vectors and greedy pick of the largest fitting coin.
   always_comb begin
      credit_ext_s = CW'(credit_q);
      coin_oh_s    = i_input_coin & (~i_input_coin + NUM_COINS'(1));
      item_oh_s    = i_select_item & (~i_select_item + NUM_ITEMS'(1));
      restock_oh_s = i_restock ? (i_restock_item & (~i_restock_item + NUM_ITEMS'(1))) : '0;
      coin_val_s   = '0;
      price_s      = '0;
      ret_val_s    = '0;
      fit_s        = '0;
      for (int i = 0; i < NUM_COINS; i++) begin
         coin_val_s = coin_val_s | (coin_oh_s[i] ? coin_value(i) : '0);
         fit_s[i]   = coin_value(i) <= credit_ext_s;
      end
      // Coin values ascend with index, so fit_s is a thermometer; keep its top bit.
      ret_oh_s = fit_s & ~(fit_s >> 1);
      for (int i = 0; i < NUM_COINS; i++) begin
         ret_val_s = ret_val_s | (ret_oh_s[i] ? coin_value(i) : '0);
      end
      for (int i = 0; i < NUM_ITEMS; i++) begin
         price_s = price_s | (item_oh_s[i] ? item_price(i) : '0);
      end
      coin_ok_s = (coin_oh_s != '0) && ((credit_ext_s + coin_val_s) <= CREDIT_MAX);
      sel_ok_s  = (item_oh_s & avail_q) != '0;
   end

   // Next state, credit, timer, pulses and per-slot stock.
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      timer_d     = timer_q;
      stock_d     = stock_q;
      item_d      = '0;
      coin_d      = '0;
      stock_sum_s = '0;
      case (state_q)
         S_IDLE, S_CREDIT: begin
            if (i_trigger_return && ((state_q == S_CREDIT) || (credit_q != '0))) begin
               state_d = S_RETURN;
               timer_d = '0;
            end else begin
               coin_d   = coin_ok_s ? '0 : coin_oh_s;
               item_d   = sel_ok_s ? item_oh_s : '0;
               credit_d = TOTAL_BITS'(credit_ext_s + (coin_ok_s ? coin_val_s : '0)
                                      - (sel_ok_s ? price_s : '0));
               if (coin_ok_s || sel_ok_s) begin
                  state_d = S_CREDIT;
                  timer_d = TW'(WAIT_CYCLES);
               end else if ((state_q == S_CREDIT) && (timer_q <= TW'(1))) begin
                  state_d = S_RETURN;
                  timer_d = '0;
               end else if (state_q == S_CREDIT) begin
                  timer_d = timer_q - TW'(1);
               end else begin
                  timer_d = timer_q;
               end
            end
         end
         S_RETURN: begin
            if (ret_oh_s != '0) begin
               coin_d   = ret_oh_s;
               credit_d = TOTAL_BITS'(credit_ext_s - ret_val_s);
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Dispense is taken off before the restock quantity is added and saturated.
      for (int i = 0; i < NUM_ITEMS; i++) begin
         stock_sum_s = {1'b0, stock_q[i]} - {{STOCK_BITS{1'b0}}, item_d[i]}
                       + (restock_oh_s[i] ? {1'b0, i_restock_qty} : '0);
         stock_d[i]  = (stock_sum_s > STOCK_MAX) ? STOCK_MAX[STOCK_BITS-1:0]
                                                 : stock_sum_s[STOCK_BITS-1:0];
      end
      avail_d = avail_of(state_d, credit_d, stock_d);
      busy_d  = (state_d == S_RETURN);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         credit_q <= '0;
         timer_q  <= '0;
         stock_q  <= {NUM_ITEMS{STOCK_BITS'(STOCK_INIT)}};
         item_q   <= '0;
         coin_q   <= '0;
         avail_q  <= avail_of(S_IDLE, '0, {NUM_ITEMS{STOCK_BITS'(STOCK_INIT)}});
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         timer_q  <= timer_d;
         stock_q  <= stock_d;
         item_q   <= item_d;
         coin_q   <= coin_d;
         avail_q  <= avail_d;
         busy_q   <= busy_d;
      end
   end

   assign o_available_item = avail_q;
   assign o_output_item    = item_q;
   assign o_return_coin    = coin_q;
   assign o_current_total  = credit_q;
   assign o_busy           = busy_q;

endmodule

// File: tb/tb_vending_change_controller.sv
// Self-checking bench for vending_change_controller: directed scenarios plus random
// traffic compared against a transaction-level model of credit, stock and change.
module tb_vending_change_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  i_input_coin;
   logic [3:0]  i_select_item;
   logic        i_trigger_return;
   logic        i_restock;
   logic [3:0]  i_restock_item;
   logic [3:0]  i_restock_qty;
   logic [3:0]  o_available_item;
   logic [3:0]  o_output_item;
   logic [2:0]  o_return_coin;
   logic [30:0] o_current_total;
   logic        o_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vending_change_controller dut (
      .clk              (clk),
      .reset            (reset),
      .i_input_coin     (i_input_coin),
      .i_select_item    (i_select_item),
      .i_trigger_return (i_trigger_return),
      .i_restock        (i_restock),
      .i_restock_item   (i_restock_item),
      .i_restock_qty    (i_restock_qty),
      .o_available_item (o_available_item),
      .o_output_item    (o_output_item),
      .o_return_coin    (o_return_coin),
      .o_current_total  (o_current_total),
      .o_busy           (o_busy)
   );

   // Reference model: credit as a plain number, change as a planned list of coins.
   int     cv[3] = '{100, 500, 1000};
   int     pr[4] = '{400, 500, 1000, 2000};
   longint credit_max = 64'd2147483647;
   longint m_credit;
   int     m_stock[4];
   int     m_mode;   // 0 idle, 1 holding credit, 2 paying change
   int     m_timer;
   int     m_q[$];
   logic [3:0] e_item;
   logic [2:0] e_coin;

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [3:0] m_avail();
      logic [3:0] a;
      a = 4'b0000;
      for (int i = 0; i < 4; i++) a[i] = (pr[i] <= m_credit) && (m_stock[i] > 0) && (m_mode != 2);
      return a;
   endfunction

   task automatic plan_change();
      longint c;
      c = m_credit;
      m_q.delete();
      while (c >= cv[0]) begin
         for (int k = 2; k >= 0; k--) begin
            if (cv[k] <= c) begin
               m_q.push_back(k);
               c -= cv[k];
               break;
            end
         end
      end
      m_mode = 2;
   endtask

   task automatic model_step();
      int ci, si, ri, idx;
      bit acc;
      longint old;
      e_item = 4'b0000;
      e_coin = 3'b000;
      if (reset) begin
         m_credit = 0; m_mode = 0; m_timer = 0; m_q.delete();
         for (int i = 0; i < 4; i++) m_stock[i] = 5;
         return;
      end
      if (m_mode == 2) begin
         if (m_q.size() > 0) begin
            idx = m_q.pop_front();
            e_coin[idx] = 1'b1;
            m_credit -= cv[idx];
         end else begin
            m_mode = 0;
         end
      end else if (i_trigger_return && (m_mode == 1 || m_credit != 0)) begin
         plan_change();
      end else begin
         acc = 0;
         old = m_credit;
         ci = lowest({1'b0, i_input_coin});
         si = lowest(i_select_item);
         if (ci >= 0) begin
            if (old + cv[ci] <= credit_max) begin m_credit += cv[ci]; acc = 1; end
            else e_coin[ci] = 1'b1;
         end
         if (si >= 0 && pr[si] <= old && m_stock[si] > 0) begin
            m_credit -= pr[si]; m_stock[si]--; e_item[si] = 1'b1; acc = 1;
         end
         if (acc) begin
            m_mode = 1; m_timer = 100;
         end else if (m_mode == 1) begin
            m_timer--;
            if (m_timer == 0) plan_change();
         end
      end
      ri = lowest(i_restock_item);
      if (i_restock && ri >= 0) begin
         m_stock[ri] += int'(i_restock_qty);
         if (m_stock[ri] > 15) m_stock[ri] = 15;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic [2:0] c, input logic [3:0] s, input logic t);
      i_input_coin = c; i_select_item = s; i_trigger_return = t;
      i_restock = 1'b0; i_restock_item = 4'b0000; i_restock_qty = 4'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(3'b000, 4'b0000, 1'b0);
      tick(); tick();
      reset = 1'b0;
      checks++; if (o_current_total !== 31'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", o_current_total); end
      checks++; if (o_available_item !== 4'b0000) begin errors++; $display("FAIL reset_avail: got %b want 0000", o_available_item); end
      checks++; if ({o_busy, o_output_item, o_return_coin} !== 8'd0) begin errors++; $display("FAIL reset_pulses: got %b want 0", {o_busy, o_output_item, o_return_coin}); end
   endtask

   task automatic test_coins();
      drive(3'b100, 4'b0000, 1'b0); tick();
      drive(3'b000, 4'b0000, 1'b0);
      checks++; if (o_current_total !== 31'd1000) begin errors++; $display("FAIL coin1000_total: got %0d want 1000", o_current_total); end
      drive(3'b010, 4'b0000, 1'b0); tick();
      drive(3'b000, 4'b0000, 1'b0);
      checks++; if (o_current_total !== 31'd1500) begin errors++; $display("FAIL coin500_total: got %0d want 1500", o_current_total); end
      checks++; if (o_available_item !== 4'b0111) begin errors++; $display("FAIL avail_1500: got %b want 0111", o_available_item); end
   endtask

   task automatic test_select();
      drive(3'b000, 4'b0100, 1'b0); tick();
      drive(3'b000, 4'b0000, 1'b0);
      checks++; if (o_output_item !== 4'b0100) begin errors++; $display("FAIL sel2_pulse: got %b want 0100", o_output_item); end
      checks++; if (o_current_total !== 31'd500) begin errors++; $display("FAIL sel2_total: got %0d want 500", o_current_total); end
      tick();
      checks++; if (o_output_item !== 4'b0000) begin errors++; $display("FAIL sel2_one_cycle: got %b want 0000", o_output_item); end
      checks++; if (o_available_item !== 4'b0011) begin errors++; $display("FAIL avail_500: got %b want 0011", o_available_item); end
   endtask

   task automatic test_return();
      logic [2:0] seq [5];
      int busy_cnt;
      seq = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b000};
      busy_cnt = 0;
      drive(3'b100, 4'b0000, 1'b0); tick();
      drive(3'b001, 4'b0000, 1'b0); tick();
      drive(3'b000, 4'b0000, 1'b1); tick();
      drive(3'b000, 4'b0000, 1'b0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         busy_cnt += int'(o_busy);
         checks++; if (o_return_coin !== seq[k]) begin errors++; $display("FAIL change_seq[%0d]: got %b want %b", k, o_return_coin, seq[k]); end
      end
      checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL busy_cycles: got %0d want 4", busy_cnt); end
      checks++; if (o_current_total !== 31'd0 || o_busy !== 1'b0) begin errors++; $display("FAIL return_end: total %0d busy %b want 0 0", o_current_total, o_busy); end
      // Return with zero credit in IDLE is ignored, so the coin is credited.
      drive(3'b001, 4'b0000, 1'b1); tick();
      drive(3'b000, 4'b0000, 1'b0);
      checks++; if (o_busy !== 1'b0 || o_current_total !== 31'd100) begin errors++; $display("FAIL idle_return_ignored: busy %b total %0d want 0 100", o_busy, o_current_total); end
   endtask

   task automatic test_timeout();
      int n100, nother;
      n100 = 0; nother = 0;
      for (int k = 0; k < 3; k++) begin drive(3'b001, 4'b0000, 1'b0); tick(); end
      drive(3'b000, 4'b0000, 1'b0);
      repeat (99) tick();
      checks++; if (o_busy !== 1'b0 || o_current_total !== 31'd400) begin errors++; $display("FAIL timeout_early: busy %b total %0d want 0 400", o_busy, o_current_total); end
      tick();
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL timeout_fire: busy %b want 1", o_busy); end
      drive(3'b010, 4'b0000, 1'b0); tick();
      drive(3'b000, 4'b0000, 1'b0);
      checks++; if (o_current_total !== 31'd300) begin errors++; $display("FAIL return_coin_ignored: got %0d want 300", o_current_total); end
      if (o_return_coin == 3'b001) n100++; else nother++;
      repeat (4) begin
         tick();
         if (o_return_coin == 3'b001) n100++; else if (o_return_coin != 3'b000) nother++;
      end
      checks++; if (n100 !== 4 || nother !== 0) begin errors++; $display("FAIL auto_return_coins: got %0d/%0d want 4/0", n100, nother); end
      checks++; if (o_busy !== 1'b0 || o_current_total !== 31'd0) begin errors++; $display("FAIL auto_return_end: busy %b total %0d want 0 0", o_busy, o_current_total); end
   endtask

   task automatic test_stock();
      int got;
      reset = 1'b1; drive(3'b000, 4'b0000, 1'b0); tick(); reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive(3'b010, 4'b0000, 1'b0); tick();
         drive(3'b000, 4'b0001, 1'b0); tick();
         checks++; if (o_output_item !== 4'b0001) begin errors++; $display("FAIL buy0[%0d]: got %b want 0001", k, o_output_item); end
      end
      drive(3'b000, 4'b0000, 1'b0);
      checks++; if (o_available_item !== 4'b0010) begin errors++; $display("FAIL sold_out_avail: got %b want 0010", o_available_item); end
      drive(3'b000, 4'b0001, 1'b0); tick();
      checks++; if (o_output_item !== 4'b0000 || o_current_total !== 31'd500) begin errors++; $display("FAIL sold_out_ignored: item %b total %0d want 0000 500", o_output_item, o_current_total); end
      drive(3'b000, 4'b0000, 1'b0);
      i_restock = 1'b1; i_restock_item = 4'b0001; i_restock_qty = 4'd15; tick();
      i_restock_qty = 4'd3; tick();
      drive(3'b000, 4'b0000, 1'b0);
      for (int k = 0; k < 6; k++) begin drive(3'b100, 4'b0000, 1'b0); tick(); end
      got = 0;
      for (int k = 0; k < 16; k++) begin
         drive(3'b000, 4'b0001, 1'b0); tick();
         if (o_output_item == 4'b0001) got++;
      end
      drive(3'b000, 4'b0000, 1'b0);
      checks++; if (got !== 15) begin errors++; $display("FAIL restock_saturate: dispensed %0d want 15", got); end
      checks++; if (o_current_total !== 31'd500) begin errors++; $display("FAIL restock_total: got %0d want 500", o_current_total); end
   endtask

   task automatic test_combo();
      reset = 1'b1; drive(3'b000, 4'b0000, 1'b0); tick(); reset = 1'b0;
      drive(3'b010, 4'b0010, 1'b0); tick();
      checks++; if (o_output_item !== 4'b0000 || o_current_total !== 31'd500) begin errors++; $display("FAIL old_credit_avail: item %b total %0d want 0000 500", o_output_item, o_current_total); end
      drive(3'b000, 4'b0001, 1'b0); tick();
      for (int k = 0; k < 3; k++) begin drive(3'b001, 4'b0000, 1'b0); tick(); end
      checks++; if (o_current_total !== 31'd400) begin errors++; $display("FAIL combo_setup: got %0d want 400", o_current_total); end
      drive(3'b010, 4'b0001, 1'b0); tick();
      checks++; if (o_output_item !== 4'b0001 || o_current_total !== 31'd500) begin errors++; $display("FAIL coin_and_select: item %b total %0d want 0001 500", o_output_item, o_current_total); end
      drive(3'b100, 4'b0000, 1'b0); tick();
      drive(3'b000, 4'b0000, 1'b1); tick();
      drive(3'b000, 4'b0000, 1'b0); tick();
      checks++; if (o_return_coin !== 3'b100) begin errors++; $display("FAIL pre_reset_change: got %b want 100", o_return_coin); end
      reset = 1'b1; tick(); reset = 1'b0;
      checks++; if ({o_busy, o_return_coin, o_available_item} !== 8'd0 || o_current_total !== 31'd0) begin errors++; $display("FAIL reset_mid_return: busy %b coin %b avail %b total %0d want all 0", o_busy, o_return_coin, o_available_item, o_current_total); end
      tick();
      checks++; if (o_busy !== 1'b0 || o_return_coin !== 3'b000) begin errors++; $display("FAIL change_discarded: busy %b coin %b want 0 000", o_busy, o_return_coin); end
   endtask

   task automatic test_random();
      reset = 1'b1; drive(3'b000, 4'b0000, 1'b0); tick(); reset = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         i_input_coin     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         i_select_item    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         i_trigger_return = ($urandom_range(0, 29) == 0);
         i_restock        = ($urandom_range(0, 15) == 0);
         i_restock_item   = 4'($urandom_range(0, 15));
         i_restock_qty    = 4'($urandom_range(0, 15));
         reset            = ($urandom_range(0, 599) == 0);
         tick();
         checks++;
         if ({o_current_total, o_available_item, o_output_item, o_return_coin, o_busy} !==
             {31'(m_credit), m_avail(), e_item, e_coin, (m_mode == 2)}) begin
            errors++;
            $display("FAIL random[%0d]: got total %0d avail %b item %b coin %b busy %b want %0d %b %b %b %b",
                     n, o_current_total, o_available_item, o_output_item, o_return_coin, o_busy,
                     m_credit, m_avail(), e_item, e_coin, (m_mode == 2));
         end
      end
      reset = 1'b0;
      drive(3'b000, 4'b0000, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      drive(3'b000, 4'b0000, 1'b0);
      test_reset();
      test_coins();
      test_select();
      test_return();
      test_timeout();
      test_stock();
      test_combo();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
